// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the pipelined LC-3b core.
// Holds the PC and fetches from the I-cache with a read/resp handshake.
// A one-entry buffer holds a word that arrives while decode is stalled.
// A redirect that arrives during a miss waits for the outstanding response,
// discards it, and then fetches from the latest target.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] tgt_q, tgt_d;
  logic [15:0] buf_ins_q, buf_ins_d;
  logic [15:0] buf_pc_q, buf_pc_d;
  logic [15:0] ins_q, ins_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic [15:0] ifpc2_q, ifpc2_d;
  logic        valid_q, valid_d;

  logic        accept;
  logic [15:0] rpc;
  logic [15:0] pc_inc;

  // Targets are halfword aligned; the low bit is ignored.
  assign rpc    = {redirect_pc[15:1], 1'b0};
  assign pc_inc = pc_q + 16'd2;
  assign accept = !stall || !valid_q;

  assign imem_read    = (state_q != HOLD);
  assign imem_address = pc_q;
  assign instruction  = ins_q;
  assign pc_out       = ifpc_q;
  assign pc_plus2_out = ifpc2_q;
  assign valid_out    = valid_q;

  // Next-state logic: the redirect is checked first so that it takes priority over accept.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    buf_ins_d = buf_ins_q;
    buf_pc_d  = buf_pc_q;
    ins_d     = ins_q;
    ifpc_d    = ifpc_q;
    ifpc2_d   = ifpc2_q;
    valid_d   = valid_q;

    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          valid_d = 1'b0;
          if (imem_resp) begin
            pc_d = rpc;
          end else begin
            // The request cannot be aborted, so keep the address stable and
            // remember where to resume.
            tgt_d   = rpc;
            state_d = KILL;
          end
        end else if (imem_resp) begin
          pc_d = pc_inc;
          if (accept) begin
            ins_d   = imem_rdata;
            ifpc_d  = pc_q;
            ifpc2_d = pc_inc;
            valid_d = 1'b1;
          end else begin
            buf_ins_d = imem_rdata;
            buf_pc_d  = pc_q;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = rpc;
          state_d = FETCH;
        end else if (accept) begin
          ins_d   = buf_ins_q;
          ifpc_d  = buf_pc_q;
          ifpc2_d = buf_pc_q + 16'd2;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end
      KILL: begin
        if (redirect) begin
          tgt_d   = rpc;
          valid_d = 1'b0;
        end
        if (imem_resp) begin
          pc_d    = redirect ? rpc : tgt_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and pipeline registers, with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      tgt_q     <= '0;
      buf_ins_q <= '0;
      buf_pc_q  <= '0;
      ins_q     <= '0;
      ifpc_q    <= '0;
      ifpc2_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      buf_ins_q <= buf_ins_d;
      buf_pc_q  <= buf_pc_d;
      ins_q     <= ins_d;
      ifpc_q    <= ifpc_d;
      ifpc2_q   <= ifpc2_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage.
// Every delivered word is queued when its response is driven.
// A monitor pops the queue whenever the IF/ID register takes a new value.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instruction;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2_out;
  logic        valid_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] pc;
  } exp_t;
  exp_t sb[$];

  logic [47:0] prev_tuple = '0;
  logic        prev_v = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .pc_plus2_out (pc_plus2_out),
    .valid_out    (valid_out)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: a new IF/ID value must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (valid_out && (!prev_v || {instruction, pc_out, pc_plus2_out} != prev_tuple)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 16'(sb.size()), 16'd1);
      end else begin
        e = sb.pop_front();
        chk("mon_ins", instruction, e.ins);
        chk("mon_pc", pc_out, e.pc);
        chk("mon_pc2", pc_plus2_out, e.pc + 16'd2);
      end
    end
    prev_v     = valid_out;
    prev_tuple = {instruction, pc_out, pc_plus2_out};
  end

  // Drives the inputs for one cycle, starting at a falling edge.
  task automatic cyc(input logic rsp, input logic [15:0] rd, input logic st,
                     input logic rdr, input logic [15:0] rpc);
    @(negedge clk);
    imem_resp   = rsp;
    imem_rdata  = rd;
    stall       = st;
    redirect    = rdr;
    redirect_pc = rpc;
  endtask

  // Returns a same-cycle hit at the expected address and queues it for delivery.
  task automatic hit(input logic [15:0] addr, input logic [15:0] data);
    exp_t e;
    cyc(1'b1, data, 1'b0, 1'b0, 16'h0000);
    chk("hit_read", 16'(imem_read), 16'd1);
    chk("hit_addr", imem_address, addr);
    e.ins = data;
    e.pc  = addr;
    sb.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, 16'(valid_out), 16'd0);
    chk({tag, "_ins"}, instruction, 16'h0000);
    chk({tag, "_pc"}, pc_out, 16'h0000);
    chk({tag, "_pc2"}, pc_plus2_out, 16'h0000);
    chk({tag, "_addr"}, imem_address, 16'h0000);
  endtask

  initial begin
    // Reset and back-to-back hits
    #1;
    check_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_read", 16'(imem_read), 16'd1);
    hit(16'h0000, 16'h1111);
    hit(16'h0002, 16'h2222);
    hit(16'h0004, 16'h3333);

    // Miss with stall, buffered word, then release
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b1, 16'h000E);
    hit(16'h000E, 16'h0E0E);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    chk("miss_addr1", imem_address, 16'h0010);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    chk("miss_addr2", imem_address, 16'h0010);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    chk("miss_addr3", imem_address, 16'h0010);
    cyc(1'b1, 16'h1010, 1'b1, 1'b0, 16'h0000);
    chk("miss_addr4", imem_address, 16'h0010);
    sb.push_back('{ins: 16'h1010, pc: 16'h0010});
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    chk("hold_read", 16'(imem_read), 16'd0);
    chk("hold_ins", instruction, 16'h0E0E);
    chk("hold_pc", pc_out, 16'h000E);
    chk("hold_valid", 16'(valid_out), 16'd1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("hold_read2", 16'(imem_read), 16'd0);
    chk("hold_ins2", instruction, 16'h0E0E);
    hit(16'h0012, 16'h1212);
    chk("unbuf_ins", instruction, 16'h1010);

    // Redirect into a pending miss
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b1, 16'h001E);
    hit(16'h001E, 16'h1E1E);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("kill_addr0", imem_address, 16'h0020);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0400);
    chk("kill_valid_pre", 16'(valid_out), 16'd1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("kill_valid", 16'(valid_out), 16'd0);
    chk("kill_addr1", imem_address, 16'h0020);
    chk("kill_read", 16'(imem_read), 16'd1);
    cyc(1'b1, 16'h2020, 1'b0, 1'b0, 16'h0000);
    chk("kill_addr2", imem_address, 16'h0020);
    hit(16'h0400, 16'h4040);

    // Two redirects during one miss; the later target wins
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("dbl_addr0", imem_address, 16'h0402);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0400);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0600);
    chk("dbl_addr1", imem_address, 16'h0402);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000);
    chk("dbl_addr2", imem_address, 16'h0402);
    hit(16'h0600, 16'h6060);

    // Redirect, stall and response in the same cycle
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b1, 16'h0801);
    chk("sim_addr0", imem_address, 16'h0602);
    chk("sim_valid_pre", 16'(valid_out), 16'd1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("sim_valid", 16'(valid_out), 16'd0);
    chk("sim_addr1", imem_address, 16'h0800);
    hit(16'h0800, 16'h8080);

    // Wrap of the PC
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b1, 16'hFFFE);
    hit(16'hFFFE, 16'hFEFE);
    hit(16'h0000, 16'h0A0A);
    chk("wrap_pc2", pc_plus2_out, 16'h0000);
    chk("wrap_pc", pc_out, 16'hFFFE);

    // Asynchronous reset in the middle of a miss
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("miss2_addr", imem_address, 16'h0002);
    chk("miss2_valid", 16'(valid_out), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    chk("arst_read", 16'(imem_read), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    hit(16'h0000, 16'h0B0B);
    repeat (3) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("sb_drain", 16'(sb.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined LC-3b core. Holds the PC, issues instruction reads to the L1 instruction cache with a read/resp handshake, and presents the fetched instruction to the decode stage. Accepts branch/jump/trap redirects and a decode-side stall. Discards any fetch that is in flight when a redirect arrives.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.

- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  downstream hold; IF/ID register must not change while stall=1 and valid_out=1.
- redirect  in  1  taken control transfer from a later stage; flushes IF/ID and refetches.
- redirect_pc  in  16  redirect target; bit 0 forced to 0 internally.
- imem_read  out  1  instruction read request to the I-cache.
- imem_address  out  16  read address; equals the PC register.
- imem_resp  in  1  single-cycle read completion.
- imem_rdata  in  16  instruction word; valid only when imem_resp=1.
- instruction  out  16  IF/ID instruction to decode.
- pc_out  out  16  address of `instruction`.
- pc_plus2_out  out  16  pc_out+2 (link/adjust base for decode/execute).
- valid_out  out  1  IF/ID holds a real instruction; when 0, decode treats `instruction` as NOP.

## Operation
- The IF/ID register accepts a new value when `accept = !stall || !valid_out`.
- The memory contract is fixed:
  - Once imem_read=1, imem_address stays stable until imem_resp.
  - A request cannot be aborted.
  - imem_resp may arrive in the same cycle as imem_read (hit).
- FSM states: FETCH, HOLD, KILL.
- **FETCH**: imem_read=1.
  - redirect=1:
    - Clear valid_out.
    - If imem_resp=1: drop rdata, pc<=redirect_pc, stay FETCH.
    - Else: tgt<=redirect_pc, go KILL. pc is unchanged, so the address stays stable.
  - imem_resp=1 and accept:
    - IF/ID <= {rdata, pc, pc+2}, valid_out<=1.
    - pc<=pc+2, stay FETCH.
  - imem_resp=1 and !accept:
    - buf <= {rdata, pc, pc+2}.
    - pc<=pc+2, go HOLD.
  - imem_resp=0: hold.
- **HOLD**: imem_read=0; one-entry buffer full.
  - redirect=1: drop buf, clear valid_out, pc<=redirect_pc, go FETCH.
  - Else if accept: IF/ID<=buf, valid_out<=1, go FETCH.
- **KILL**: imem_read=1, address = old pc.
  - redirect=1: tgt<=redirect_pc, clear valid_out. The latest target wins.
  - When imem_resp=1: discard rdata, pc<=tgt (or redirect_pc if redirect is also 1 that cycle), go FETCH.
- Arithmetic: pc+2 is 16-bit and wraps modulo 2^16 (16'hFFFE -> 16'h0000).
- Priority: redirect > accept. A redirect clears valid_out even while stall=1.

## Timing
- Reset (async, immediate) values:
  - pc=RESET_PC, state=FETCH.
  - valid_out=0, instruction=16'h0000, pc_out=16'h0000, pc_plus2_out=16'h0000.
  - imem_read=1 once rst_n deasserts; it is combinational from state.
- Latency: imem_resp in cycle N -> valid_out/instruction updated at edge ending N. Decode sees the instruction in cycle N+1.
- Throughput: one instruction per cycle on back-to-back same-cycle hits.
- Redirect in cycle N, no outstanding miss: imem_address=redirect_pc in cycle N+1.
- Redirect during a miss: the new address appears the cycle after the outstanding imem_resp.
- Stall: outputs bit-stable for every cycle with stall=1 and valid_out=1. At most one extra instruction is fetched into buf.
- Reset mid-miss: state returns to FETCH. The cache is reset by the same rst_n, so no stale imem_resp is expected.

## Test plan
- **Reset and hits**
  - Stimulus: RESET_PC=16'h0000; release rst_n; same-cycle hits returning 16'h1111, 16'h2222, 16'h3333.
  - Required: imem_address 0,2,4 on consecutive cycles; instruction/pc_out = 1111/0000, 2222/0002, 3333/0004 on successive cycles; pc_plus2_out = pc_out+2.
- **Miss with stall**
  - Stimulus: imem_resp delayed 3 cycles on address 16'h0010; stall=1 during the response.
  - Required: imem_address held at 0010 for all 4 cycles; IF/ID unchanged while stalled; imem_read=0 in HOLD; buffered word appears the edge after stall drops; next fetch address 0012.
- **Redirect into a pending miss**
  - Stimulus: redirect to 16'h0400 while a miss on 16'h0020 is pending.
  - Required: valid_out=0 next cycle; 0020 data discarded; first new imem_address = 0400 the cycle after the resp.
- **Double redirect**
  - Stimulus: redirects to 16'h0400, then 16'h0600, both during one miss.
  - Required: fetch resumes at 0600.
- **Simultaneous events**
  - Stimulus: redirect=1, stall=1 and imem_resp=1 in the same cycle; redirect_pc=16'h0801.
  - Required: valid_out=0; rdata dropped; next imem_address = 16'h0800.
- **Wrap and async reset**
  - Stimulus: sequential hits from pc=16'hFFFE; then assert rst_n=0 asynchronously mid-miss.
  - Required: pc_plus2_out=0000 and next address 16'h0000 after the wrap; on reset, outputs return to reset values without waiting for a clk edge.
